// File: rtl/lc_ctrl_pkg.sv
// rtl/lc_ctrl_pkg.sv - shared types and constants for the serial logic-cell adder controller
package lc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Bit positions on the logic cell LI bus when it is in adder mode
  localparam int LI_A = 0;
  localparam int LI_B = 1;

endpackage

// File: rtl/lc_serial_shreg.sv
// rtl/lc_serial_shreg.sv - WIDTH-bit register with parallel load, right shift and synchronous clear
module lc_serial_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_en_i,
  input  logic             shift_in_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_en_i) begin
      data_d = {shift_in_i, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/lc_serial_add_ctrl.sv
// rtl/lc_serial_add_ctrl.sv - bit-serial add/subtract controller driving one external logic cell
module lc_serial_add_ctrl
  import lc_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic [3:0]       lc_li,
  output logic             lc_ci,
  output logic             lc_qen,
  input  logic             lc_fz,
  input  logic             lc_co
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic            res_cout_q;
  logic            res_valid_q;

  logic             accept;
  logic             run;
  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic [WIDTH-1:0] sum_w;
  logic [3:0]       li_w;

  assign accept = (state_q == ST_IDLE) && op_valid;
  assign run    = (state_q == ST_RUN);

  // B is stored pre-inverted for subtract so the cell always adds; carry-in 1 completes two's complement
  lc_serial_shreg #(.WIDTH(WIDTH)) u_opa (
    .clk_i      (QCK),
    .clr_i      (QRT),
    .load_i     (accept),
    .load_data_i(op_a),
    .shift_en_i (1'b0),
    .shift_in_i (1'b0),
    .data_o     (a_w)
  );

  lc_serial_shreg #(.WIDTH(WIDTH)) u_opb (
    .clk_i      (QCK),
    .clr_i      (QRT),
    .load_i     (accept),
    .load_data_i(op_b ^ {WIDTH{op_sub}}),
    .shift_en_i (1'b0),
    .shift_in_i (1'b0),
    .data_o     (b_w)
  );

  // Sum bits enter at the MSB, so after WIDTH shifts bit idx lands at position idx
  lc_serial_shreg #(.WIDTH(WIDTH)) u_sum (
    .clk_i      (QCK),
    .clr_i      (QRT),
    .load_i     (1'b0),
    .load_data_i({WIDTH{1'b0}}),
    .shift_en_i (run),
    .shift_in_i (lc_fz),
    .data_o     (sum_w)
  );

  always_comb begin
    li_w = 4'b0000;
    if (run) begin
      li_w[LI_A] = a_w[idx_q];
      li_w[LI_B] = b_w[idx_q];
    end
  end

  always_ff @(posedge QCK) begin
    if (QRT) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      res_cout_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            carry_q <= (op_e'(op_sub) == OP_SUB);
          end
        end
        ST_RUN: begin
          carry_q <= lc_co;
          if (idx_q == IDXW'(WIDTH - 1)) begin
            idx_q       <= '0;
            res_cout_q  <= lc_co;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_sum   = sum_w;
  assign res_cout  = res_cout_q;
  assign lc_li     = li_w;
  assign lc_ci     = run & carry_q;
  assign lc_qen    = run;

endmodule

// File: tb/tb_lc_serial_add_ctrl.sv
// tb/tb_lc_serial_add_ctrl.sv - self-checking bench with logic cell model and transaction-level reference
module tb_lc_serial_add_ctrl;

  localparam int W = 16;

  logic         QCK;
  logic         QRT;
  logic         op_valid;
  logic         op_ready;
  logic         op_sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic [3:0]   lc_li;
  logic         lc_ci;
  logic         lc_qen;
  logic         lc_fz;
  logic         lc_co;

  int n_tests = 0;
  int n_fail  = 0;

  lc_serial_add_ctrl #(.WIDTH(W)) dut (
    .QCK      (QCK),
    .QRT      (QRT),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_sub   (op_sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
    .res_cout (res_cout),
    .lc_li    (lc_li),
    .lc_ci    (lc_ci),
    .lc_qen   (lc_qen),
    .lc_fz    (lc_fz),
    .lc_co    (lc_co)
  );

  // Logic cell in adder mode: full adder on LI0, LI1 and CI
  assign lc_fz = lc_li[0] ^ lc_li[1] ^ lc_ci;
  assign lc_co = (lc_li[0] & lc_li[1]) | (lc_li[0] & lc_ci) | (lc_li[1] & lc_ci);

  initial begin
    QCK = 1'b0;
    forever #5 QCK = ~QCK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an operation in flight, how many bits have been issued, and its arithmetic answer
  logic         m_init = 1'b0;
  logic         m_active = 1'b0;
  logic         m_sum_zero = 1'b0;
  int           m_issued = 0;
  logic [W-1:0] m_a, m_bp;
  logic         m_sub;
  logic [W-1:0] m_exp_sum;
  logic         m_exp_cout;

  always @(negedge QCK) begin
    longint mk;
    longint cexp;
    if (m_init) begin
      if (!m_active) begin
        chk("cmp_ready_idle", op_ready, 1);
        chk("cmp_valid_idle", res_valid, 0);
        chk("cmp_qen_idle", lc_qen, 0);
        chk("cmp_li_idle", lc_li, 0);
        chk("cmp_ci_idle", lc_ci, 0);
        if (m_sum_zero) chk("cmp_sum_after_reset", res_sum, 0);
      end else if (m_issued < W) begin
        mk   = (64'd1 << m_issued) - 1;
        cexp = ((longint'(m_a) & mk) + (longint'(m_bp) & mk) + longint'(m_sub)) >> m_issued;
        chk("cmp_ready_run", op_ready, 0);
        chk("cmp_valid_run", res_valid, 0);
        chk("cmp_qen_run", lc_qen, 1);
        chk("cmp_li_run", lc_li, {2'b00, m_bp[m_issued], m_a[m_issued]});
        chk("cmp_ci_run", lc_ci, cexp[0]);
      end else begin
        chk("cmp_ready_done", op_ready, 0);
        chk("cmp_valid_done", res_valid, 1);
        chk("cmp_qen_done", lc_qen, 0);
        chk("cmp_li_done", lc_li, 0);
        chk("cmp_sum_done", res_sum, m_exp_sum);
        chk("cmp_cout_done", res_cout, m_exp_cout);
      end
    end
    if (QRT) begin
      m_init     = 1'b1;
      m_active   = 1'b0;
      m_issued   = 0;
      m_sum_zero = 1'b1;
    end else if (m_init) begin
      if (!m_active) begin
        if (op_valid) begin
          m_active   = 1'b1;
          m_issued   = 0;
          m_sum_zero = 1'b0;
          m_a        = op_a;
          m_sub      = op_sub;
          m_bp       = op_sub ? ~op_b : op_b;
          m_exp_sum  = op_sub ? W'(op_a - op_b) : W'(op_a + op_b);
          m_exp_cout = op_sub ? (op_a >= op_b) : ((32'(op_a) + 32'(op_b)) >> W) != 0;
        end
      end else if (m_issued < W) begin
        m_issued++;
      end else if (res_ready) begin
        m_active = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic [W-1:0] es, input logic ec, input int stall);
    int n;
    chk("op_ready_before", op_ready, 1);
    op_a = a; op_b = b; op_sub = sub; op_valid = 1'b1;
    @(posedge QCK); #1;
    op_valid = 1'b0;
    n = 1;
    while (!res_valid && n < 100) begin
      @(posedge QCK); #1;
      n++;
    end
    chk("latency_edges", n, W + 1);
    chk("res_sum", res_sum, es);
    chk("res_cout", res_cout, ec);
    for (int i = 0; i < stall; i++) begin
      @(posedge QCK); #1;
      chk("stall_valid", res_valid, 1);
      chk("stall_sum", res_sum, es);
      chk("stall_ready", op_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge QCK); #1;
    res_ready = 1'b0;
    chk("post_hs_ready", op_ready, 1);
    chk("post_hs_valid", res_valid, 0);
  endtask

  initial begin
    int n;
    QRT = 1'b1; op_valid = 1'b0; op_sub = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (2) @(posedge QCK);
    #1;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_qen", lc_qen, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_cout", res_cout, 0);
    QRT = 1'b0;
    @(posedge QCK); #1;

    run_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
    run_op(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 0);
    run_op(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 0);
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 3);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 10);

    // Second request held during RUN must be dropped, not queued
    op_a = 16'h0010; op_b = 16'h0020; op_sub = 1'b0; op_valid = 1'b1;
    @(posedge QCK); #1;
    op_a = 16'hAAAA; op_b = 16'h5555; op_sub = 1'b1;
    n = 1;
    while (!res_valid && n < 100) begin
      chk("ignore_ready_low", op_ready, 0);
      @(posedge QCK); #1;
      n++;
    end
    chk("ignore_latency", n, W + 1);
    op_valid = 1'b0;
    chk("ignore_sum", res_sum, 16'h0030);
    chk("ignore_cout", res_cout, 0);
    res_ready = 1'b1;
    @(posedge QCK); #1;
    res_ready = 1'b0;
    chk("ignore_post_ready", op_ready, 1);
    repeat (3) @(posedge QCK);
    #1;
    chk("ignore_no_queued_op", lc_qen, 0);

    // Abort at bit 7
    op_a = 16'h00FF; op_b = 16'h0001; op_sub = 1'b0; op_valid = 1'b1;
    @(posedge QCK); #1;
    op_valid = 1'b0;
    repeat (7) @(posedge QCK);
    #1;
    chk("abort_bit7_li", lc_li, 4'b0001);
    QRT = 1'b1;
    res_ready = 1'b1;
    @(posedge QCK); #1;
    QRT = 1'b0;
    res_ready = 1'b0;
    chk("abort_ready", op_ready, 1);
    chk("abort_valid", res_valid, 0);
    chk("abort_qen", lc_qen, 0);
    chk("abort_sum", res_sum, 0);
    repeat (20) @(posedge QCK);
    #1;
    chk("abort_no_result", res_valid, 0);

    run_op(16'h00A5, 16'h005A, 1'b0, 16'h00FF, 1'b0, 0);

    repeat (2) @(posedge QCK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
